// File: rtl/pcs_scr_pkg.sv
// Shared definitions for the G(x) = x^58 + x^39 + 1 self-synchronous scrambler:
// state type, tap positions and the single-bit recurrence step.
package pcs_scr_pkg;

   localparam int SCR_LEN = 58;
   localparam int SCR_TAP = 39;

   typedef logic [SCR_LEN-1:0] scr_state_t;

   // One wire bit: returns {state_next, data_out}. S[0] is the newest bit.
   function automatic logic [SCR_LEN:0] scr_step(input scr_state_t state,
                                                 input logic       data,
                                                 input logic       mode);
      logic out_bit;
      logic fb;
      out_bit = data ^ state[SCR_TAP-1] ^ state[SCR_LEN-1];
      fb      = mode ? data : out_bit;
      return {state[SCR_LEN-2:0], fb, out_bit};
   endfunction

endpackage

// File: rtl/pcs_scr_core.sv
// Combinational unrolled scrambler recurrence across one beat of DATA_W bits,
// bit 0 being the first on the wire.
module pcs_scr_core
   import pcs_scr_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int MODE   = 0
) (
   input  scr_state_t        state,
   input  logic [DATA_W-1:0] data,
   output scr_state_t        state_next,
   output logic [DATA_W-1:0] data_out
);

   always_comb begin
      scr_state_t       s;
      logic [SCR_LEN:0] r;
      s        = state;
      r        = '0;
      data_out = '0;
      // NOTE: blocking assignments here build a ripple chain through s, one step per bit.
      for (int i = 0; i < DATA_W; i++) begin
         r           = scr_step(s, data[i], MODE != 0);
         s           = r[SCR_LEN:1];
         data_out[i] = r[0];
      end
      state_next = s;
   end

endmodule

// File: rtl/pcs_scrambler_param.sv
// 64b/66b PCS payload scrambler/descrambler with valid/ready flow control,
// seed load, per-beat bypass and a lock flag after 58 processed payload bits.
module pcs_scrambler_param
   import pcs_scr_pkg::*;
#(
   parameter int         DATA_W      = 64,
   parameter int         MODE        = 0,
   parameter int         BIT_REVERSE = 0,
   parameter scr_state_t SEED        = {SCR_LEN{1'b1}}
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              bypass,
   input  logic              seed_load,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              locked
);

   localparam int                CNT_W    = $clog2(SCR_LEN + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(SCR_LEN);

   scr_state_t        lfsr;
   scr_state_t        state_in;
   scr_state_t        state_next;
   logic [CNT_W-1:0]  lock_cnt;
   logic [CNT_W-1:0]  lock_base;
   logic [CNT_W-1:0]  lock_next;
   int unsigned       lock_sum;
   logic [DATA_W-1:0] core_in;
   logic [DATA_W-1:0] core_out;
   logic [DATA_W-1:0] scr_data;
   logic              accept;

   assign in_ready = rst_n && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign locked   = (lock_cnt == LOCK_MAX);

   // A seed_load in the same cycle as a beat makes that beat start from SEED.
   assign state_in  = seed_load ? SEED : lfsr;
   assign lock_base = seed_load ? '0 : lock_cnt;

   always_comb begin
      lock_sum  = 32'(lock_base) + DATA_W;
      lock_next = (lock_sum >= SCR_LEN) ? LOCK_MAX : lock_sum[CNT_W-1:0];
   end

   always_comb begin
      core_in  = '0;
      scr_data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (BIT_REVERSE != 0) begin
            core_in[i]  = in_data[DATA_W-1-i];
            scr_data[i] = core_out[DATA_W-1-i];
         end else begin
            core_in[i]  = in_data[i];
            scr_data[i] = core_out[i];
         end
      end
   end

   pcs_scr_core #(
      .DATA_W (DATA_W),
      .MODE   (MODE)
   ) u_core (
      .state      (state_in),
      .data       (core_in),
      .state_next (state_next),
      .data_out   (core_out)
   );

   // NOTE: reset is synchronous, so it is tested inside the clocked branch, not in the sensitivity list.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         lfsr      <= SEED;
         lock_cnt  <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= bypass ? in_data : scr_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept && !bypass) begin
            lfsr     <= state_next;
            lock_cnt <= lock_next;
         end else if (seed_load) begin
            lfsr     <= SEED;
            lock_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pcs_scrambler_param.sv
// Directed bench for pcs_scrambler_param: reset, impulse/inverse, backpressure,
// scrambler->descrambler chain, bypass/seed handling and a width sweep.
module tb_pcs_scrambler_param;

   localparam logic [63:0] IMPULSE = 64'h0400_0080_0000_0001;
   localparam logic [63:0] BEAT2   = 64'h0030_0000_0000_4000;
   localparam logic [63:0] BYP_VAL = 64'hDEAD_BEEF_0123_4567;
   localparam int          N_CHAIN = 10000;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // A: scrambler, seed 0
   logic        a_in_valid, a_in_ready, a_bypass, a_seed_load, a_out_valid, a_out_ready, a_locked;
   logic [63:0] a_in_data, a_out_data;
   // B: descrambler, seed 0
   logic        b_in_valid, b_in_ready, b_out_valid, b_locked;
   logic [63:0] b_in_data, b_out_data;
   // C -> D: scrambler with odd seed feeding descrambler with default seed
   logic        c_in_valid, c_in_ready, c_out_valid, c_locked;
   logic [63:0] c_in_data, c_out_data;
   logic        d_in_ready, d_out_valid, d_out_ready, d_locked;
   logic [63:0] d_out_data;
   // E/F/G: width sweep scramblers, seed 0
   logic        w_in_valid;
   logic        e_in_ready, e_out_valid, e_locked;
   logic        f_in_ready, f_out_valid, f_locked;
   logic        g_in_ready, g_out_valid, g_locked;
   logic [15:0] e_in_data, e_out_data;
   logic [31:0] f_in_data, f_out_data;
   logic [65:0] g_in_data, g_out_data;

   pcs_scrambler_param #(.DATA_W(64), .MODE(0), .SEED(58'h0)) u_a (
      .CLK(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .bypass(a_bypass), .seed_load(a_seed_load),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .locked(a_locked));

   pcs_scrambler_param #(.DATA_W(64), .MODE(1), .SEED(58'h0)) u_b (
      .CLK(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .bypass(1'b0), .seed_load(1'b0),
      .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .locked(b_locked));

   pcs_scrambler_param #(.DATA_W(64), .MODE(0), .SEED(58'h2AB_CDEF_0123_4567)) u_c (
      .CLK(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .bypass(1'b0), .seed_load(1'b0),
      .out_valid(c_out_valid), .out_ready(d_in_ready), .out_data(c_out_data), .locked(c_locked));

   pcs_scrambler_param #(.DATA_W(64), .MODE(1)) u_d (
      .CLK(clk), .rst_n(rst_n), .in_valid(c_out_valid), .in_ready(d_in_ready),
      .in_data(c_out_data), .bypass(1'b0), .seed_load(1'b0),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .locked(d_locked));

   pcs_scrambler_param #(.DATA_W(16), .MODE(0), .SEED(58'h0)) u_e (
      .CLK(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(e_in_ready),
      .in_data(e_in_data), .bypass(1'b0), .seed_load(1'b0),
      .out_valid(e_out_valid), .out_ready(1'b1), .out_data(e_out_data), .locked(e_locked));

   pcs_scrambler_param #(.DATA_W(32), .MODE(0), .SEED(58'h0)) u_f (
      .CLK(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(f_in_ready),
      .in_data(f_in_data), .bypass(1'b0), .seed_load(1'b0),
      .out_valid(f_out_valid), .out_ready(1'b1), .out_data(f_out_data), .locked(f_locked));

   pcs_scrambler_param #(.DATA_W(66), .MODE(0), .SEED(58'h0)) u_g (
      .CLK(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(g_in_ready),
      .in_data(g_in_data), .bypass(1'b0), .seed_load(1'b0),
      .out_valid(g_out_valid), .out_ready(1'b1), .out_data(g_out_data), .locked(g_locked));

   task automatic test_reset();
      rst_n      = 1'b0;
      a_in_valid = 1'b1;
      a_in_data  = '1;
      repeat (3) begin
         @(negedge clk);
         checks += 4;
         if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
         if (a_out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
         if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", a_locked); end
         if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", a_in_ready); end
      end
      rst_n      = 1'b1;
      a_in_valid = 1'b0;
      a_in_data  = '0;
   endtask

   task automatic test_impulse();
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 64'h1;
      @(negedge clk);
      a_in_valid = 1'b0;
      checks += 3;
      if (a_out_valid !== 1'b1) begin errors++; $display("FAIL impulse_valid got %b want 1", a_out_valid); end
      if (a_out_data !== IMPULSE) begin errors++; $display("FAIL impulse_data got %h want %h", a_out_data, IMPULSE); end
      if (a_locked !== 1'b1) begin errors++; $display("FAIL impulse_locked got %b want 1", a_locked); end
   endtask

   task automatic test_inverse();
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = IMPULSE;
      @(negedge clk);
      b_in_valid = 1'b0;
      checks += 2;
      if (b_out_valid !== 1'b1) begin errors++; $display("FAIL inverse_valid got %b want 1", b_out_valid); end
      if (b_out_data !== 64'h1) begin errors++; $display("FAIL inverse_data got %h want 1", b_out_data); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 64'h1;
      a_seed_load = 1'b1;
      @(negedge clk);
      a_seed_load = 1'b0;
      a_in_data   = 64'h0;
      repeat (5) begin
         #1;
         checks += 3;
         if (a_out_data !== IMPULSE) begin errors++; $display("FAIL hold_data got %h want %h", a_out_data, IMPULSE); end
         if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", a_out_valid); end
         if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", a_in_ready); end
         @(negedge clk);
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++;
      if (a_out_data !== BEAT2) begin errors++; $display("FAIL release_data got %h want %h", a_out_data, BEAT2); end
   endtask

   task automatic test_bypass_seed();
      a_seed_load = 1'b1;
      @(negedge clk);
      a_seed_load = 1'b0;
      checks += 3;
      if (a_locked !== 1'b0) begin errors++; $display("FAIL seed_locked got %b want 0", a_locked); end
      if (a_out_data !== BEAT2) begin errors++; $display("FAIL seed_keeps_data got %h want %h", a_out_data, BEAT2); end
      if (a_out_valid !== 1'b0) begin errors++; $display("FAIL seed_drain_valid got %b want 0", a_out_valid); end
      a_in_valid = 1'b1;
      a_bypass   = 1'b1;
      a_in_data  = BYP_VAL;
      @(negedge clk);
      a_bypass  = 1'b0;
      a_in_data = 64'h1;
      checks += 2;
      if (a_out_data !== BYP_VAL) begin errors++; $display("FAIL bypass_data got %h want %h", a_out_data, BYP_VAL); end
      if (a_locked !== 1'b0) begin errors++; $display("FAIL bypass_locked got %b want 0", a_locked); end
      @(negedge clk);
      a_seed_load = 1'b1;
      checks += 2;
      if (a_out_data !== IMPULSE) begin errors++; $display("FAIL after_bypass_data got %h want %h", a_out_data, IMPULSE); end
      if (a_locked !== 1'b1) begin errors++; $display("FAIL after_bypass_locked got %b want 1", a_locked); end
      @(negedge clk);
      a_seed_load = 1'b0;
      a_in_valid  = 1'b0;
      checks += 2;
      if (a_out_data !== IMPULSE) begin errors++; $display("FAIL seed_beat_data got %h want %h", a_out_data, IMPULSE); end
      if (a_locked !== 1'b1) begin errors++; $display("FAIL seed_beat_locked got %b want 1", a_locked); end
   endtask

   task automatic test_chain();
      logic [63:0] q[$];
      logic [63:0] exp;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      logic        c_take = 1'b1;
      logic        d_take;
      logic        lock_pending = 1'b0;
      while (got < N_CHAIN && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (lock_pending) begin
            lock_pending = 1'b0;
            checks++;
            if (c_locked !== 1'b1) begin errors++; $display("FAIL chain_locked got %b want 1", c_locked); end
         end
         if (c_take) begin
            if (sent < N_CHAIN) begin
               c_in_valid = 1'b1;
               c_in_data  = {$urandom, $urandom};
            end else begin
               c_in_valid = 1'b0;
            end
         end
         d_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         c_take = c_in_valid && c_in_ready;
         d_take = d_out_valid && d_out_ready;
         if (d_take) begin
            exp = q.pop_front();
            if (got >= 1) begin
               checks++;
               if (d_out_data !== exp) begin errors++; $display("FAIL chain_beat %0d got %h want %h", got, d_out_data, exp); end
            end
            got++;
         end
         if (c_take) begin
            q.push_back(c_in_data);
            sent++;
            if (sent == 1) lock_pending = 1'b1;
         end
      end
      c_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      checks++;
      if (got != N_CHAIN) begin errors++; $display("FAIL chain_timeout got %0d beats want %0d", got, N_CHAIN); end
   endtask

   task automatic test_width_sweep();
      logic [79:0]  exp;
      logic [79:0]  acc16;
      logic [95:0]  acc32;
      logic [131:0] acc66;
      exp     = '0;
      exp[0]  = 1'b1;
      exp[39] = 1'b1;
      exp[58] = 1'b1;
      exp[78] = 1'b1;
      acc16   = '0;
      acc32   = '0;
      acc66   = '0;
      @(negedge clk);
      w_in_valid = 1'b1;
      e_in_data  = 16'h1;
      f_in_data  = 32'h1;
      g_in_data  = 66'h1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         e_in_data = '0;
         f_in_data = '0;
         g_in_data = '0;
         acc16[k*16 +: 16] = e_out_data;
         if (k < 3) acc32[k*32 +: 32] = f_out_data;
         if (k < 2) acc66[k*66 +: 66] = g_out_data;
         if (k == 0) begin
            checks++;
            if (g_locked !== 1'b1) begin errors++; $display("FAIL w66_locked got %b want 1", g_locked); end
         end
         if (k == 2) begin
            checks++;
            if (e_locked !== 1'b0) begin errors++; $display("FAIL w16_locked_48 got %b want 0", e_locked); end
         end
         if (k == 3) begin
            checks++;
            if (e_locked !== 1'b1) begin errors++; $display("FAIL w16_locked_64 got %b want 1", e_locked); end
         end
      end
      w_in_valid = 1'b0;
      checks += 3;
      if (acc16 !== exp) begin errors++; $display("FAIL w16_taps got %h want %h", acc16, exp); end
      if (acc32[79:0] !== exp) begin errors++; $display("FAIL w32_taps got %h want %h", acc32[79:0], exp); end
      if (acc66[79:0] !== exp) begin errors++; $display("FAIL w66_taps got %h want %h", acc66[79:0], exp); end
   endtask

   initial begin
      a_in_valid = 1'b0; a_in_data = '0; a_bypass = 1'b0; a_seed_load = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0;
      c_in_valid = 1'b0; c_in_data = '0; d_out_ready = 1'b1;
      w_in_valid = 1'b0; e_in_data = '0; f_in_data = '0; g_in_data = '0;
      test_reset();
      test_impulse();
      test_inverse();
      test_backpressure();
      test_bypass_seed();
      test_chain();
      test_width_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
